axis_video_tpg: RTL
===================

# axis_video_tpg

AXI4-Stream video test-pattern generator that sits directly upstream of the passthrough monitor stage and drives its slave stream. It emits fixed-size frames in the same framing the monitor measures: `tuser[0]` marks start-of-frame and `tlast` marks end-of-line. A fixed idle gap separates frames, so the monitor's column, line and fps measurements are deterministic. A free-running frame counter is exported for software cross-checks.

## Interface
- `WIDTH`, 48, tdata width; C = WIDTH/3 bits per component, packed as {c2,c1,c0}; WIDTH must be a multiple of 3.
- `TUSER_WIDTH`, 1, tuser width; only bit 0 is driven and the upper bits are 0.
- `H_ACTIVE`, 1920, pixels per line; ≥ 8 and a multiple of 8.
- `V_ACTIVE`, 1080, lines per frame; ≥ 1.
- `FRAME_GAP`, 16, idle cycles (tvalid=0) after each frame; ≥ 1.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  run request.
- `pattern_sel`  in  2  pattern: 0 ramp, 1 colour bars, 2 checker, 3 frame-number fill.
- `m_axis_tvalid`  out  1  pixel valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tdata`  out  WIDTH  pixel.
- `m_axis_tlast`  out  1  last pixel of line.
- `m_axis_tuser`  out  TUSER_WIDTH  bit 0 set on the first pixel of a frame.
- `frame_cnt`  out  32  number of completed frames.

## Operation
- The FSM has three states: IDLE, ACTIVE, GAP.
- **IDLE:**
  - tvalid=0.
  - `enable`=1 → ACTIVE, with x=0, y=0, and `pattern_sel` latched into `pat_r`.
- **ACTIVE:**
  - tvalid=1. A beat transfers on tvalid&tready.
  - On each beat, x increments.
  - At x=H_ACTIVE-1: x→0 and y increments.
  - On the beat with x=H_ACTIVE-1 and y=V_ACTIVE-1: enter GAP, frame_cnt+1, gap counter loaded with FRAME_GAP-1.
- **GAP:**
  - tvalid=0 and the gap counter decrements each cycle.
  - At 0: if `enable`=1, → ACTIVE (x=y=0, `pat_r` re-latched); otherwise → IDLE.
- Deasserting `enable` mid-frame does not truncate the frame; it completes and the FSM stops after the GAP.
- `pattern_sel` changes take effect only at a frame start.
- Sideband signals:
  - tuser[0] = (x==0 && y==0) while tvalid.
  - tlast = (x==H_ACTIVE-1) while tvalid.
- Patterns (all component arithmetic is mod 2^C):
  - 0, ramp: every component = x[C-1:0].
  - 1, bars: 8 bars, each H_ACTIVE/8 pixels wide. b = bar index 0..7, tracked by a sub-counter (no divider). Component k = all-ones if b[k]=1, else 0.
  - 2, checker: all components = all-ones if x[3]^y[3]=1, else 0.
  - 3, fill: all components = frame_cnt[C-1:0].
- frame_cnt wraps from 2^32-1 to 0.

## Timing
- All outputs are registered.
- Reset values: tvalid=0, tdata=0, tlast=0, tuser=0, frame_cnt=0; FSM=IDLE with x=y=0.
- Start latency: `enable` sampled high in IDLE → tvalid=1 on the next cycle.
- AXI-Stream stall rule: while tvalid=1 and tready=0, tdata, tlast and tuser hold stable. tvalid never drops mid-frame.
- Back-to-back frames: the last beat of frame N is followed by exactly FRAME_GAP cycles of tvalid=0, then tvalid=1 with tuser=1. This is independent of tready during the gap.
- frame_cnt updates on the cycle after the last beat, i.e. the first GAP cycle.
- Reset asserted mid-frame: all outputs clear immediately. After release, a new frame starts from x=y=0 only once `enable` is seen.

## Configuration
- `AXIS_TPG_MOTION_EN` defined:
  - Ramp (pattern 0) uses (x + frame_cnt)[C-1:0], so the ramp scrolls by one code per frame.
  - Checker (pattern 2) uses (x + frame_cnt)[3] ^ y[3].
- Undefined: patterns 0 and 2 are static, as specified in Operation.
- Bars and fill are unaffected either way.

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=4, FRAME_GAP=3, WIDTH=48.
- **Basic frame:** reset, then enable=1 with tready=1 constantly, pattern 0 → 32 beats per frame; tuser on beat 0 only; tlast on beats 7/15/23/31; tdata c0 = 0..7 per line; then 3 tvalid=0 cycles; frame_cnt=1.
- **Backpressure:** random 50% tready → beat sequence identical to tready=1; tdata/tlast/tuser unchanged across every stalled cycle; no tvalid drop inside a frame.
- **Mid-frame control changes:** enable→0 at beat 10 → frame finishes (32 beats), 3-cycle gap, then IDLE with tvalid=0. pattern_sel 0→1 mid-frame → takes effect only at the next frame.
- **Bars:** pattern 1 → beat n of each line has tdata = {c2,c1,c0} with each component 16'hFFFF or 0 per bits of n (H_ACTIVE/8=1). Beat 5 = {FFFF,0000,FFFF}.
- **Reset mid-frame:** aresetn low at beat 12 → all outputs 0 asynchronously, frame_cnt=0. After release with enable=1, the first beat has tuser=1 and x=0.
- **Motion:** with `AXIS_TPG_MOTION_EN`, pattern 0, frame 2 (frame_cnt=2) → line pixels c0 = 2..9.

Source files
------------

// File: rtl/axis_video_tpg.sv
// AXI4-Stream video test-pattern generator: fixed-size frames (tuser[0]=SOF, tlast=EOL)
// separated by a fixed idle gap. Define AXIS_TPG_MOTION_EN to scroll the ramp and checker per frame.
module axis_video_tpg #(
    parameter int WIDTH       = 48,
    parameter int TUSER_WIDTH = 1,
    parameter int H_ACTIVE    = 1920,
    parameter int V_ACTIVE    = 1080,
    parameter int FRAME_GAP   = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   enable,
    input  logic [1:0]             pattern_sel,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [WIDTH-1:0]       m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [31:0]            frame_cnt
);

    localparam int C       = WIDTH / 3;
    localparam int X_W     = $clog2(H_ACTIVE);
    localparam int Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int G_W     = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam int BAR_LEN = H_ACTIVE / 8;
    localparam int B_W     = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

    localparam logic [X_W-1:0] X_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_ACTIVE - 1);
    localparam logic [G_W-1:0] GAP_LOAD = G_W'(FRAME_GAP - 1);
    localparam logic [B_W-1:0] BAR_LAST = B_W'(BAR_LEN - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

    logic [1:0]       state, state_n;
    logic [X_W-1:0]   x, x_n;
    logic [Y_W-1:0]   y, y_n;
    logic [B_W-1:0]   bar_px, bar_px_n;
    logic [2:0]       bar_idx, bar_idx_n;
    logic [G_W-1:0]   gap_cnt, gap_n;
    logic [1:0]       pat_r, pat_n;
    logic [31:0]      fc_r, fc_n;
    logic             load_pix, clear_pix;

    logic             tvalid_r;
    logic [WIDTH-1:0] tdata_r;
    logic             tlast_r;
    logic             tuser_r;

    // Pixel value for a coordinate; bar index comes from a sub-counter so no divider is needed.
    function automatic logic [WIDTH-1:0] pixel(
        input logic [1:0]     pat,
        input logic [X_W-1:0] px,
        input logic [Y_W-1:0] py,
        input logic [2:0]     bar,
        input logic [31:0]    fc
    );
        logic [C-1:0]     comp;
        logic             chk;
        logic [WIDTH-1:0] res;
        res  = '0;
        comp = '0;
`ifdef AXIS_TPG_MOTION_EN
        chk  = (((4'(px) + 4'(fc)) ^ 4'(py)) & 4'h8) != 4'h0;
`else
        chk  = ((4'(px) ^ 4'(py)) & 4'h8) != 4'h0;
`endif
        case (pat)
`ifdef AXIS_TPG_MOTION_EN
            2'd0:    comp = C'(px) + C'(fc);
`else
            2'd0:    comp = C'(px);
`endif
            2'd2:    comp = chk ? '1 : '0;
            2'd3:    comp = C'(fc);
            default: comp = '0;
        endcase
        for (int k = 0; k < 3; k++) begin
            if (pat == 2'd1)
                res[k*C +: C] = {C{bar[k]}};
            else
                res[k*C +: C] = comp;
        end
        return res;
    endfunction

    // Frame sequencing: coordinates always describe the pixel currently presented.
    always_comb begin
        state_n   = state;
        x_n       = x;
        y_n       = y;
        bar_px_n  = bar_px;
        bar_idx_n = bar_idx;
        gap_n     = gap_cnt;
        pat_n     = pat_r;
        fc_n      = fc_r;
        load_pix  = 1'b0;
        clear_pix = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n   = S_ACTIVE;
                    x_n       = '0;
                    y_n       = '0;
                    bar_px_n  = '0;
                    bar_idx_n = '0;
                    pat_n     = pattern_sel;
                    load_pix  = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (m_axis_tready) begin
                    if (x == X_LAST) begin
                        x_n       = '0;
                        bar_px_n  = '0;
                        bar_idx_n = '0;
                        if (y == Y_LAST) begin
                            state_n   = S_GAP;
                            gap_n     = GAP_LOAD;
                            fc_n      = fc_r + 32'd1;
                            clear_pix = 1'b1;
                        end else begin
                            y_n      = y + 1'b1;
                            load_pix = 1'b1;
                        end
                    end else begin
                        x_n      = x + 1'b1;
                        load_pix = 1'b1;
                        if (bar_px == BAR_LAST) begin
                            bar_px_n  = '0;
                            bar_idx_n = bar_idx + 1'b1;
                        end else begin
                            bar_px_n = bar_px + 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    if (enable) begin
                        state_n   = S_ACTIVE;
                        x_n       = '0;
                        y_n       = '0;
                        bar_px_n  = '0;
                        bar_idx_n = '0;
                        pat_n     = pattern_sel;
                        load_pix  = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Output registers only move on a new pixel or at frame end, so they hold through stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            bar_px   <= '0;
            bar_idx  <= '0;
            gap_cnt  <= '0;
            pat_r    <= '0;
            fc_r     <= '0;
            tvalid_r <= 1'b0;
            tdata_r  <= '0;
            tlast_r  <= 1'b0;
            tuser_r  <= 1'b0;
        end else begin
            state   <= state_n;
            x       <= x_n;
            y       <= y_n;
            bar_px  <= bar_px_n;
            bar_idx <= bar_idx_n;
            gap_cnt <= gap_n;
            pat_r   <= pat_n;
            fc_r    <= fc_n;
            if (load_pix) begin
                tvalid_r <= 1'b1;
                tdata_r  <= pixel(pat_n, x_n, y_n, bar_idx_n, fc_n);
                tlast_r  <= (x_n == X_LAST);
                tuser_r  <= (x_n == '0) && (y_n == '0);
            end else if (clear_pix) begin
                tvalid_r <= 1'b0;
                tdata_r  <= '0;
                tlast_r  <= 1'b0;
                tuser_r  <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tuser  = TUSER_WIDTH'(tuser_r);
    assign frame_cnt     = fc_r;

endmodule
